// File: rtl/cc_bus_sequencer.sv
// Two-requester bus sequencer: round-robin burst grants, bounded burst length,
// and a fixed turnaround gap between bus owners.
module cc_bus_sequencer #(
  parameter int DATA_W     = 7,
  parameter int MAX_BURST  = 4,
  parameter int TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              a_req,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam int GAP_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(TURNAROUND - 1);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, GAP} state_t;

  state_t             state, state_d;
  logic               src_d;
  logic               rr_ptr, rr_d;
  logic [CNT_W-1:0]   beat_cnt, beat_d;
  logic [GAP_W-1:0]   gap_cnt, gap_d;
  logic               sel_req, sel_last;

  assign sel_req  = (state == GNT_A) ? a_req  : (state == GNT_B) ? b_req  : 1'b0;
  assign sel_last = (state == GNT_A) ? a_last : (state == GNT_B) ? b_last : 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      out_src  <= 1'b0;
      beat_cnt <= '0;
      gap_cnt  <= '0;
      rr_ptr   <= 1'b0;
    end else begin
      state    <= state_d;
      out_src  <= src_d;
      beat_cnt <= beat_d;
      gap_cnt  <= gap_d;
      rr_ptr   <= rr_d;
    end
  end

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state;
    src_d   = out_src;
    beat_d  = beat_cnt;
    gap_d   = gap_cnt;
    rr_d    = rr_ptr;
    unique case (state)
      IDLE: begin
        if (en) begin
          if (a_req && b_req) begin
            state_d = rr_ptr ? GNT_B : GNT_A;
            src_d   = rr_ptr;
            rr_d    = ~rr_ptr;
          end else if (a_req) begin
            state_d = GNT_A;
            src_d   = 1'b0;
          end else if (b_req) begin
            state_d = GNT_B;
            src_d   = 1'b1;
          end
        end
      end
      GNT_A, GNT_B: begin
        // A withdrawn request ends the burst even without a transfer.
        if (!sel_req || (out_ready && (sel_last || beat_cnt == LAST_BEAT))) begin
          state_d = GAP;
          beat_d  = '0;
          gap_d   = GAP_LOAD;
        end else if (out_ready) begin
          beat_d = beat_cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_d = IDLE;
        else               gap_d   = gap_cnt - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are suppressed while rst is high so an aborted burst never acks.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    if (!rst) begin
      if (state == GNT_A && a_req) begin
        out_valid = 1'b1;
        out_data  = a_data;
        a_ack     = out_ready;
      end else if (state == GNT_B && b_req) begin
        out_valid = 1'b1;
        out_data  = b_data;
        b_ack     = out_ready;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cc_bus_sequencer.sv
// Directed and randomized checks of cc_bus_sequencer against a transaction-level
// model of owners, beat counts, gap time and round-robin preference.
module tb_cc_bus_sequencer;
  localparam int DATA_W     = 7;
  localparam int MAX_BURST  = 4;
  localparam int TURNAROUND = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en, a_req, a_last, b_req, b_last, out_ready;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ack, b_ack, out_valid, out_src, busy;
  logic [DATA_W-1:0] out_data;

  cc_bus_sequencer #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .TURNAROUND(TURNAROUND)) dut (
    .clk(clk), .rst(rst), .en(en),
    .a_req(a_req), .a_data(a_data), .a_last(a_last), .a_ack(a_ack),
    .b_req(b_req), .b_data(b_data), .b_last(b_last), .b_ack(b_ack),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: owner 0=nobody, 1=A, 2=B; gap_left = turnaround cycles still to spend.
  int m_owner = 0, m_beats = 0, m_gap_left = 0, m_fav = 0, m_src = 0;
  int acks_a = 0, acks_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model, cross the rising edge.
  task automatic step();
    logic              ev, ea, eb, req, last, done;
    logic [DATA_W-1:0] ed;
    int                side;
    @(negedge clk);
    ev = !rst && ((m_owner == 1 && a_req) || (m_owner == 2 && b_req));
    ed = !ev ? '0 : (m_owner == 1 ? a_data : b_data);
    ea = ev && m_owner == 1 && out_ready;
    eb = ev && m_owner == 2 && out_ready;
    check("out_valid", 32'(out_valid), 32'(ev));
    check("out_data",  32'(out_data),  32'(ed));
    check("a_ack",     32'(a_ack),     32'(ea));
    check("b_ack",     32'(b_ack),     32'(eb));
    check("busy",      32'(busy),      32'(m_owner != 0 || m_gap_left != 0));
    check("out_src",   32'(out_src),   32'(m_src));
    if (a_ack) acks_a++;
    if (b_ack) acks_b++;

    if (rst) begin
      m_owner = 0; m_beats = 0; m_gap_left = 0; m_fav = 0; m_src = 0;
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else if (m_owner == 0) begin
      if (en && (a_req || b_req)) begin
        if (a_req && b_req) begin
          side  = m_fav;
          m_fav = 1 - m_fav;
        end else begin
          side = a_req ? 0 : 1;
        end
        m_owner = side + 1;
        m_src   = side;
      end
    end else begin
      req  = (m_owner == 1) ? a_req  : b_req;
      last = (m_owner == 1) ? a_last : b_last;
      done = !req;
      if (req && out_ready) begin
        m_beats++;
        if (last || m_beats == MAX_BURST) done = 1'b1;
      end
      if (done) begin
        m_owner    = 0;
        m_beats    = 0;
        m_gap_left = TURNAROUND;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base_a, base_b;
    rst = 1'b1; en = 1'b0; out_ready = 1'b1;
    a_req = 1'b1; a_last = 1'b0; a_data = '0;
    b_req = 1'b1; b_last = 1'b0; b_data = '0;

    // Reset held with both requesters active.
    step(); step();
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
    step();

    // Single A burst ended by a_last on beat 3.
    en = 1'b1; a_req = 1'b1; a_data = 7'h15;
    step();
    acks_a = 0;
    step(); step();
    a_last = 1'b1; step();
    a_last = 1'b0; a_req = 1'b0;
    step();
    check("t2_a_acks", 32'(acks_a), 32'd3);
    step();

    // Contention: both request continuously, bursts capped at MAX_BURST.
    acks_a = 0; acks_b = 0;
    a_req = 1'b1; b_req = 1'b1; a_data = 7'h2A; b_data = 7'h33;
    repeat (14) step();
    check("t3_a_acks", 32'(acks_a), 32'd5);
    check("t3_b_acks", 32'(acks_b), 32'd4);
    check("t3_src",    32'(out_src), 32'd0);
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) step();

    // Backpressure on a B burst.
    base_b = acks_b;
    b_req = 1'b1; b_data = 7'h5A;
    step();
    out_ready = 1'b0;
    repeat (5) step();
    check("t4_no_ack", 32'(acks_b - base_b), 32'd0);
    out_ready = 1'b1; b_last = 1'b1;
    step();
    b_last = 1'b0; b_req = 1'b0;
    step(); step();
    check("t4_b_acks", 32'(acks_b - base_b), 32'd1);

    // Enable low holds IDLE; then a withdrawn burst after one beat.
    base_a = acks_a;
    en = 1'b0; a_req = 1'b1; a_data = 7'h0F;
    repeat (3) step();
    check("t5_idle", 32'(busy), 32'd0);
    en = 1'b1; step();
    en = 1'b0; step();
    a_req = 1'b0; step();
    check("t5_gap", 32'(busy), 32'd1);
    step();
    check("t5_a_acks", 32'(acks_a - base_a), 32'd1);
    en = 1'b1;

    // Reset in the middle of a B burst.
    b_req = 1'b1; b_data = 7'h44;
    step(); step();
    rst = 1'b1; step();
    rst = 1'b0; b_req = 1'b0; step();
    check("t6_idle", 32'(busy), 32'd0);
    a_req = 1'b1; b_req = 1'b1;
    step(); step();
    check("t6_a_first", 32'(out_src), 32'd0);
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      en        = ($urandom_range(0, 7) != 0);
      a_req     = ($urandom_range(0, 3) != 0);
      b_req     = ($urandom_range(0, 3) != 0);
      a_last    = ($urandom_range(0, 4) == 0);
      b_last    = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a_data    = DATA_W'($urandom);
      b_data    = DATA_W'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
